// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for a shared-ALU, single-memory RISC-V multicycle datapath.
// Decodes opcode/func3/func7 and the ALU flags, and drives all datapath enables
// and mux selects as Moore outputs of the current state. Branch PCWrite,
// ALUControl and ImmSrc also depend on the instruction fields.
//
// Optional feature: define MC_MEM_WAIT_EN to add the mem_ready handshake.
// FETCH, MEMREAD and MEMWRITE then hold until mem_ready=1.
//
// state    | meaning
// FETCH    | read instruction at PC, IR <= mem, PC <= PC+4
// DECODE   | ALUOut <= oldPC+imm (branch/jal target), dispatch on opcode
// MEMADR   | ALUOut <= rs1+imm (load/store address)
// MEMREAD  | MDR <= mem[ALUOut]
// MEMWB    | rd <= MDR
// MEMWRITE | mem[ALUOut] <= rs2
// EXEC_R   | ALUOut <= rs1 op rs2
// EXEC_I   | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | PC <= target, ALUOut <= oldPC+4 (link)
// JALR     | ALUOut <= rs1+imm (jump target)
// JALR_PC  | PC <= ALUOut, ALUOut <= oldPC+4 (link)
// LUI      | ALUOut <= 0+imm
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       lt,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR_PC  = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t state_q, state_d;
    logic   mem_rdy;
    logic   branch_taken;
    logic   unused_func7;

    // Only func7[5] (sub vs add) matters to this decoder.
    assign unused_func7 = ^{func7[6], func7[4:0]};

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // Branch condition from func3; reserved encodings fall through as not taken.
    always_comb begin
        branch_taken = 1'b0;
        case (func3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = ~lt;
            default: branch_taken = 1'b0;
        endcase
    end

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic use_sub);
        logic [2:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = use_sub ? ALU_SUB : ALU_ADD;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            3'b010:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [2:0] imm_dec(input logic [6:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_LOAD, OP_I, OP_JALR: imm = IMM_I;
            OP_STORE:               imm = IMM_S;
            OP_B:                   imm = IMM_B;
            OP_JAL:                 imm = IMM_J;
            OP_LUI:                 imm = IMM_U;
            default:                imm = 3'b000;
        endcase
        return imm;
    endfunction

    // State register; reset lands in FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; everything is forced low while rst is high
    // so an abandoned store or writeback cannot leak out during reset.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = imm_dec(opcode);
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                AdrSrc    = 1'b0;
                ALUSrcA   = 2'b00;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_rdy) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_B:              state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        // Unknown opcode retires as a NOP.
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_rdy) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = alu_dec(func3, func7[5]);
                state_d    = S_ALUWB;
            end
            S_EXEC_I: begin
                // func7 bits are immediate here, so sub is never selected.
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(func3, 1'b0);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = 2'b00;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_SUB;
                ResultSrc  = 2'b00;
                PCWrite    = branch_taken;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ResultSrc = 2'b00;
                PCWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JALR_PC;
            end
            S_JALR_PC: begin
                ResultSrc = 2'b00;
                PCWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUControl = ALU_ADD;
            ImmSrc     = 3'b000;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Scoreboard bench: each instruction pushes its expected per-cycle output
// vectors, which are popped and compared as the controller steps through it.
// Builds with or without MC_MEM_WAIT_EN; the fetch-stall case runs only with it.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       lt;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [17:0] got_vec;

    localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4,
                   T_MEMWRITE = 5, T_EXEC_R = 6, T_EXEC_I = 7, T_ALUWB = 8, T_BRANCH = 9,
                   T_JAL = 10, T_JALR = 11, T_JALR_PC = 12, T_LUI = 13;

    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func3      (func3),
        .func7      (func7),
        .zero       (zero),
        .lt         (lt),
`ifdef MC_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .instr_done (instr_done)
    );

    assign got_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done};

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b (PCW,Adr,MW,IRW,RW,RS,SA,SB,ALU,IMM,done)",
                     tag, got, exp);
        end
    endtask

    function automatic logic known_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    endfunction

    function automatic logic [17:0] exp_vec(input int s, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic z, input logic l, input logic rdy);
        logic pcw, adr, mw, irw, rw, done;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu, imm;
        {pcw, adr, mw, irw, rw, done} = '0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: imm = 3'b000;
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b1101111: imm = 3'b011;
            7'b0110111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        case (s)
            T_FETCH:    begin pcw = rdy; irw = rdy; sb = 2'b10; rs = 2'b10; end
            T_DECODE:   begin sa = 2'b01; sb = 2'b01; done = !known_op(op); end
            T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            T_MEMREAD:  adr = 1'b1;
            T_MEMWB:    begin rs = 2'b01; rw = 1'b1; done = 1'b1; end
            T_MEMWRITE: begin adr = 1'b1; mw = 1'b1; done = 1'b1; end
            T_EXEC_R, T_EXEC_I: begin
                sa = 2'b10;
                sb = (s == T_EXEC_R) ? 2'b00 : 2'b01;
                if (f3 == 3'b000)      alu = (s == T_EXEC_R && f7[5]) ? 3'b001 : 3'b000;
                else if (f3 == 3'b110) alu = 3'b011;
                else if (f3 == 3'b111) alu = 3'b010;
                else if (f3 == 3'b010) alu = 3'b101;
            end
            T_ALUWB:    begin rw = 1'b1; done = 1'b1; end
            T_BRANCH: begin
                sa = 2'b10; alu = 3'b001; done = 1'b1;
                pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z :
                      (f3 == 3'b100) ? l : (f3 == 3'b101) ? !l : 1'b0;
            end
            T_JAL, T_JALR_PC: begin pcw = 1'b1; sa = 2'b01; sb = 2'b10; end
            T_JALR:     begin sa = 2'b10; sb = 2'b01; end
            T_LUI:      begin sa = 2'b11; sb = 2'b01; end
            default:    ;
        endcase
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, done};
    endfunction

    // Called right after a falling edge; one comparison per instruction cycle.
    // rst_at >= 0 asserts rst mid-cycle at that index and abandons the rest.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic l,
                             input int stall, input int rst_at);
        int   seq[$];
        logic rdyq[$];
        logic [17:0] e;
        opcode = op; func3 = f3; func7 = f7; zero = z; lt = l;
        for (int k = 0; k < stall; k++) begin seq.push_back(T_FETCH); rdyq.push_back(1'b0); end
        seq.push_back(T_FETCH);  rdyq.push_back(1'b1);
        seq.push_back(T_DECODE); rdyq.push_back(1'b1);
        case (op)
            7'b0000011: seq = {seq, T_MEMADR, T_MEMREAD, T_MEMWB};
            7'b0100011: seq = {seq, T_MEMADR, T_MEMWRITE};
            7'b0110011: seq = {seq, T_EXEC_R, T_ALUWB};
            7'b0010011: seq = {seq, T_EXEC_I, T_ALUWB};
            7'b1100011: seq = {seq, T_BRANCH};
            7'b1101111: seq = {seq, T_JAL, T_ALUWB};
            7'b1100111: seq = {seq, T_JALR, T_JALR_PC, T_ALUWB};
            7'b0110111: seq = {seq, T_LUI, T_ALUWB};
            default: ;
        endcase
        while (rdyq.size() < seq.size()) rdyq.push_back(1'b1);
        for (int i = 0; i < seq.size(); i++)
            exp_q.push_back(exp_vec(seq[i], op, f3, f7, z, l, rdyq[i]));
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = rdyq[i];
            #1;
            e = exp_q.pop_front();
            chk($sformatf("%s cyc%0d", name, i + 1), got_vec, e);
            if (i == rst_at) begin
                #1 rst = 1'b1;
                #1 chk($sformatf("%s rst_async", name), got_vec, 18'd0);
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opcode = 7'b0110011; func3 = 3'b000; func7 = 7'd0;
        zero = 1'b0; lt = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset outputs", got_vec, 18'd0);
        @(negedge clk);
        rst = 1'b0;

        run_instr("add",     7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, -1);
        run_instr("sub",     7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, -1);
        run_instr("and",     7'b0110011, 3'b111, 7'b0000000, 0, 0, 0, -1);
        run_instr("slt",     7'b0110011, 3'b010, 7'b0000000, 0, 0, 0, -1);
        run_instr("slti",    7'b0010011, 3'b010, 7'b0000000, 0, 0, 0, -1);
        run_instr("addi_neg",7'b0010011, 3'b000, 7'b1111111, 0, 0, 0, -1);
        run_instr("ori",     7'b0010011, 3'b110, 7'b0100000, 0, 0, 0, -1);
        run_instr("lw",      7'b0000011, 3'b010, 7'b0000000, 0, 0, 0, -1);
        run_instr("sw",      7'b0100011, 3'b010, 7'b0000000, 0, 0, 0, -1);
        run_instr("bge_nlt", 7'b1100011, 3'b101, 7'b0000000, 0, 0, 0, -1);
        run_instr("bge_lt",  7'b1100011, 3'b101, 7'b0000000, 0, 1, 0, -1);
        run_instr("beq_z",   7'b1100011, 3'b000, 7'b0000000, 1, 0, 0, -1);
        run_instr("beq_nz",  7'b1100011, 3'b000, 7'b0000000, 0, 0, 0, -1);
        run_instr("bne_nz",  7'b1100011, 3'b001, 7'b0000000, 0, 1, 0, -1);
        run_instr("blt_lt",  7'b1100011, 3'b100, 7'b0000000, 1, 1, 0, -1);
        run_instr("b_rsvd",  7'b1100011, 3'b010, 7'b0000000, 1, 1, 0, -1);
        run_instr("jal",     7'b1101111, 3'b000, 7'b0000000, 0, 0, 0, -1);
        run_instr("jalr",    7'b1100111, 3'b000, 7'b0000000, 0, 0, 0, -1);
        run_instr("lui",     7'b0110111, 3'b101, 7'b0000000, 0, 0, 0, -1);
        run_instr("nop_unk", 7'b1111111, 3'b000, 7'b0000000, 0, 0, 0, -1);
        run_instr("sw_rst",  7'b0100011, 3'b010, 7'b0000000, 0, 0, 0, 3);
        run_instr("add_post",7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, -1);
`ifdef MC_MEM_WAIT_EN
        run_instr("add_wait",7'b0110011, 3'b000, 7'b0000000, 0, 0, 3, -1);
        run_instr("add_tail",7'b0110011, 3'b110, 7'b0000000, 0, 0, 0, -1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
